mem_stage_lsu: RTL

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load or store request into a word-addressed handshake with data memory. For loads it aligns and extends the returned data and supplies it to MEM/WB's IN_DMEM_OUT. It drives the pipeline-wide BUSYWAIT stall while an access is outstanding.

---
 rtl/mem_stage_lsu_if.sv | 36 +++
 rtl/mem_stage_lsu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Bus bundle between the memory-stage LSU, the EX/MEM and MEM/WB pipeline registers, and data memory.
// The master modport is the LSU; the slave modport is the pipeline/memory side.
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] IN_ALU_RESULT;
  logic [31:0]           IN_DATA2;
  logic [2:0]            IN_FUNCT3;
  logic                  IN_MEM_READ;
  logic                  IN_MEM_WRITE;
  logic [31:0]           OUT_DMEM_OUT;
  logic                  BUSYWAIT;
  logic                  ACCESS_FAULT;
  logic                  TIMEOUT_ERR;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-3:0] MEM_ADDRESS;
  logic [31:0]           MEM_WRITEDATA;
  logic [3:0]            MEM_BYTE_EN;
  logic [31:0]           MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport master (
    input  IN_ALU_RESULT, IN_DATA2, IN_FUNCT3, IN_MEM_READ, IN_MEM_WRITE,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output OUT_DMEM_OUT, BUSYWAIT, ACCESS_FAULT, TIMEOUT_ERR,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN
  );

  modport slave (
    output IN_ALU_RESULT, IN_DATA2, IN_FUNCT3, IN_MEM_READ, IN_MEM_WRITE,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  OUT_DMEM_OUT, BUSYWAIT, ACCESS_FAULT, TIMEOUT_ERR,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns a load/store into a word-addressed memory handshake,
// aligns/extends load data, and stalls the pipeline while an access is outstanding.
module mem_stage_lsu #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  mem_stage_lsu_if.master bus
);
  localparam int unsigned WA    = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [WA-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       dout_q, dout_d;
  logic              fault_q, fault_d;
  logic              tmo_q, tmo_d;

  logic [1:0]  addr_lo;
  logic        req_rd, req_any, legal, aligned, req_valid;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode: legality, alignment and store lane formatting
  always_comb begin
    addr_lo  = bus.IN_ALU_RESULT[1:0];
    req_rd   = bus.IN_MEM_READ;
    req_any  = bus.IN_MEM_READ | bus.IN_MEM_WRITE;
    legal    = 1'b0;
    aligned  = 1'b0;
    st_wdata = bus.IN_DATA2;
    st_be    = 4'b1111;
    case (bus.IN_FUNCT3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = req_rd;
      default:                legal = 1'b0;
    endcase
    case (bus.IN_FUNCT3[1:0])
      2'b00: begin
        aligned  = 1'b1;
        st_wdata = {4{bus.IN_DATA2[7:0]}};
        st_be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        aligned  = ~addr_lo[0];
        st_wdata = {2{bus.IN_DATA2[15:0]}};
        st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
    req_valid = req_any & legal & aligned;
  end

  // Load extraction uses the lane and size captured when the access started
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = bus.MEM_READDATA[7:0];
      2'd1:    ld_byte = bus.MEM_READDATA[15:8];
      2'd2:    ld_byte = bus.MEM_READDATA[23:16];
      default: ld_byte = bus.MEM_READDATA[31:24];
    endcase
    ld_half = lane_q[1] ? bus.MEM_READDATA[31:16] : bus.MEM_READDATA[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.MEM_READDATA;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    dout_d      = dout_q;
    fault_d     = 1'b0;
    tmo_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d     = req_rd ? S_READ : S_WRITE;
          mem_read_d  = req_rd;
          mem_write_d = ~req_rd;
          addr_d      = bus.IN_ALU_RESULT[ADDR_WIDTH-1:2];
          wdata_d     = st_wdata;
          be_d        = req_rd ? 4'b0000 : st_be;
          f3_d        = bus.IN_FUNCT3;
          lane_d      = addr_lo;
          cnt_d       = '0;
        end else if (req_any) begin
          fault_d = 1'b1;
        end
      end
      S_READ, S_WRITE: begin
        // Memory readiness wins over a timeout landing on the same edge
        if (!bus.MEM_BUSYWAIT) begin
          state_d     = S_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == S_READ) dout_d = ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          tmo_d       = 1'b1;
          if (state_q == S_READ) dout_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      dout_q      <= 32'd0;
      fault_q     <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      dout_q      <= dout_d;
      fault_q     <= fault_d;
      tmo_q       <= tmo_d;
    end
  end

  // Stall is combinational so the requesting instruction is held from its first cycle
  assign bus.BUSYWAIT = RESET & (((state_q == S_IDLE) & req_valid) |
                                 (state_q == S_READ) | (state_q == S_WRITE));

  assign bus.OUT_DMEM_OUT  = dout_q;
  assign bus.ACCESS_FAULT  = fault_q;
  assign bus.TIMEOUT_ERR   = tmo_q;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = addr_q;
  assign bus.MEM_WRITEDATA = wdata_q;
  assign bus.MEM_BYTE_EN   = be_q;
endmodule
